// File: rtl/mmio_controller.sv
// mmio_controller: CPU-side memory controller with wait-stated RAM and
// memory-mapped LED / switch / interrupt registers.
//
// Ports
//   clock         in   system clock, rising edge
//   reset         in   synchronous, active-high
//   req           in   CPU access request, held until ready
//   we            in   1 = write, 0 = read; valid with req
//   address       in   word address; valid with req
//   data_fromCPU  in   write data; valid with req & we
//   data_toCPU    out  read data, valid only while ready=1 (0 otherwise)
//   ready         out  one-cycle completion pulse
//   LEDs          out  LED register contents
//   switches      in   asynchronous board switches
//   irq           out  |(chg & mask), combinational from registers
//
// Memory map: [0, RAM_DEPTH) RAM; IO_BASE+0 LEDs; +1 synced switches (RO);
// +2 change latch (W1C); +3 irq mask; everything else reads 0, ignores writes.

module mmio_controller #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned RAM_DEPTH = 1024,
  parameter int unsigned RAM_WAIT  = 1,
  parameter int unsigned GPIO_CH   = 4,
  parameter int unsigned IO_BASE   = 32'h0000_FF00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_fromCPU,
  output logic [DATA_W-1:0] data_toCPU,
  output logic              ready,
  output logic [GPIO_CH-1:0] LEDs,
  input  logic [GPIO_CH-1:0] switches,
  output logic              irq
);

  localparam int unsigned RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [GPIO_CH-1:0]  leds_q;
  logic [GPIO_CH-1:0]  mask_q;
  logic [GPIO_CH-1:0]  chg_q;
  logic [GPIO_CH-1:0]  chg_d;
  logic [GPIO_CH-1:0]  sync1_q;
  logic [GPIO_CH-1:0]  sw_s_q;
  logic [GPIO_CH-1:0]  prev_q;

  logic [DATA_W-1:0]   ram [RAM_DEPTH];

  // Effective request: live inputs while idle, captured copy afterwards
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_we;
  logic [DATA_W-1:0]   cur_wdata;
  logic                is_ram;
  logic                is_io;
  logic [ADDR_W-1:0]   io_off;
  logic [RAM_AW-1:0]   ram_idx;
  logic                go_done;
  logic [DATA_W-1:0]   rd_val;
  logic                w1c;

  // Request decode and completion (commit) qualification
  always_comb begin
    cur_addr  = (state_q == IDLE) ? address      : addr_q;
    cur_we    = (state_q == IDLE) ? we           : we_q;
    cur_wdata = (state_q == IDLE) ? data_fromCPU : wdata_q;
    is_ram    = cur_addr < ADDR_W'(RAM_DEPTH);
    // Wrapping subtraction: addresses below IO_BASE land far above 3
    io_off    = cur_addr - ADDR_W'(IO_BASE);
    is_io     = !is_ram && (io_off < ADDR_W'(4));
    ram_idx   = RAM_AW'(cur_addr);
    go_done   = ((state_q == IDLE) && req && !(is_ram && (RAM_WAIT != 0))) ||
                ((state_q == WAIT) && (cnt_q == '0));

    rd_val = '0;
    if (is_ram) begin
      rd_val = ram[ram_idx];
    end else if (is_io) begin
      case (io_off[1:0])
        2'd0:    rd_val = DATA_W'(leds_q);
        2'd1:    rd_val = DATA_W'(sw_s_q);
        2'd2:    rd_val = DATA_W'(chg_q);
        default: rd_val = DATA_W'(mask_q);
      endcase
    end

    // New edges are ORed in after the clear so a same-cycle set wins
    w1c   = go_done && cur_we && is_io && (io_off[1:0] == 2'd2);
    chg_d = w1c ? (chg_q & ~cur_wdata[GPIO_CH-1:0]) : chg_q;
    chg_d = chg_d | (sw_s_q ^ prev_q);
  end

  // RAM array; never reset, write suppressed by a reset on the commit edge
  always_ff @(posedge clock) begin
    if (!reset && go_done && cur_we && is_ram) begin
      ram[ram_idx] <= cur_wdata;
    end
  end

  // Access FSM, I/O registers and switch synchronizer
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      leds_q  <= '0;
      mask_q  <= '0;
      chg_q   <= '0;
      sync1_q <= '0;
      sw_s_q  <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= switches;
      sw_s_q  <= sync1_q;
      prev_q  <= sw_s_q;
      chg_q   <= chg_d;

      ready_q <= go_done;
      rdata_q <= (go_done && !cur_we) ? rd_val : '0;

      if (go_done && cur_we && is_io) begin
        if (io_off[1:0] == 2'd0) leds_q <= cur_wdata[GPIO_CH-1:0];
        if (io_off[1:0] == 2'd3) mask_q <= cur_wdata[GPIO_CH-1:0];
      end

      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            we_q    <= we;
            wdata_q <= data_fromCPU;
            if (is_ram && (RAM_WAIT != 0)) begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(RAM_WAIT - 1);
            end else begin
              state_q <= DONE;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= DONE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready      = ready_q;
  assign data_toCPU = rdata_q;
  assign LEDs       = leds_q;
  assign irq        = |(chg_q & mask_q);

endmodule

// File: tb/tb_mmio_controller.sv
// Directed self-checking bench for mmio_controller (default parameters).
module tb_mmio_controller;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic [15:0] address;
  logic [31:0] data_fromCPU;
  logic [31:0] data_toCPU;
  logic        ready;
  logic [3:0]  LEDs;
  logic [3:0]  switches;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  mmio_controller dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .address      (address),
    .data_fromCPU (data_fromCPU),
    .data_toCPU   (data_toCPU),
    .ready        (ready),
    .LEDs         (LEDs),
    .switches     (switches),
    .irq          (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs are driven and outputs sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete bus access; returns values seen in the ready cycle
  task automatic access(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input int exp_lat, input string tag,
                        output logic [31:0] rd, output logic [3:0] led, output logic irq_v);
    int lat;
    bit got;
    req = 1'b1; we = w; address = a; data_fromCPU = d;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      lat++;
      if (ready === 1'b1) got = 1'b1;
    end
    rd = data_toCPU; led = LEDs; irq_v = irq;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    if (w) check({tag, " wr data_toCPU"}, rd, 32'h0);
    req = 1'b0; we = 1'b0; data_fromCPU = '0;
    tick();
    check({tag, " ready pulse end"}, 32'(ready), 32'h0);
    check({tag, " data idle"}, data_toCPU, 32'h0);
  endtask

  logic [31:0] rd;
  logic [3:0]  led;
  logic        irq_v;

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; address = '0; data_fromCPU = '0; switches = 4'h0;
    tick(); tick();
    check("rst ready", 32'(ready), 32'h0);
    check("rst data", data_toCPU, 32'h0);
    check("rst leds", 32'(LEDs), 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    reset = 1'b0;
    tick(); tick();

    // RAM write then read, one wait state
    access(1'b1, 16'd5, 32'hDEADBEEF, 2, "t1 ram wr", rd, led, irq_v);
    access(1'b0, 16'd5, 32'h0, 2, "t1 ram rd", rd, led, irq_v);
    check("t1 rd data", rd, 32'hDEADBEEF);
    access(1'b1, 16'd1023, 32'h13572468, 2, "ram top wr", rd, led, irq_v);
    access(1'b0, 16'd1023, 32'h0, 2, "ram top rd", rd, led, irq_v);
    check("ram top data", rd, 32'h13572468);
    access(1'b0, 16'd1024, 32'h0, 1, "ram end+1 rd", rd, led, irq_v);
    check("ram end+1 data", rd, 32'h0);

    // LED register
    access(1'b1, 16'hFF00, 32'hFFFF_FFFA, 1, "t2 led wr", rd, led, irq_v);
    check("t2 leds at ready", 32'(led), 32'hA);
    access(1'b0, 16'hFF00, 32'h0, 1, "t2 led rd", rd, led, irq_v);
    check("t2 led rd data", rd, 32'h0000000A);

    // Switch change latch and masked irq
    access(1'b1, 16'hFF03, 32'h4, 1, "t3 mask wr", rd, led, irq_v);
    switches = 4'b0100;
    tick(); tick();
    check("t3 irq not yet", 32'(irq), 32'h0);
    tick();
    check("t3 irq set", 32'(irq), 32'h1);
    access(1'b0, 16'hFF02, 32'h0, 1, "t3 chg rd", rd, led, irq_v);
    check("t3 chg data", rd, 32'h4);
    access(1'b0, 16'hFF01, 32'h0, 1, "t3 sw rd", rd, led, irq_v);
    check("t3 sw data", rd, 32'h4);
    access(1'b1, 16'hFF01, 32'hF, 1, "t3 sw wr ignored", rd, led, irq_v);
    access(1'b1, 16'hFF02, 32'h4, 1, "t3 w1c", rd, led, irq_v);
    check("t3 irq cleared", 32'(irq_v), 32'h0);
    access(1'b0, 16'hFF02, 32'h0, 1, "t3 chg rd2", rd, led, irq_v);
    check("t3 chg cleared", rd, 32'h0);

    // Set wins over simultaneous write-1-to-clear
    access(1'b1, 16'hFF03, 32'hF, 1, "t4 mask wr", rd, led, irq_v);
    switches = 4'b0110;
    tick(); tick();
    access(1'b1, 16'hFF02, 32'hF, 1, "t4 w1c", rd, led, irq_v);
    check("t4 irq", 32'(irq_v), 32'h1);
    access(1'b0, 16'hFF02, 32'h0, 1, "t4 chg rd", rd, led, irq_v);
    check("t4 chg set wins", rd, 32'h2);
    access(1'b0, 16'hFF03, 32'h0, 1, "t4 mask rd", rd, led, irq_v);
    check("t4 mask data", rd, 32'hF);

    // Unmapped addresses
    access(1'b1, 16'd0, 32'h12345678, 2, "t5 ram0 wr", rd, led, irq_v);
    access(1'b0, 16'h8000, 32'h0, 1, "t5 unmapped rd", rd, led, irq_v);
    check("t5 unmapped data", rd, 32'h0);
    access(1'b1, 16'h8000, 32'hFFFFFFFF, 1, "t5 unmapped wr", rd, led, irq_v);
    access(1'b1, 16'hFF04, 32'hFFFFFFFF, 1, "t5 io+4 wr", rd, led, irq_v);
    access(1'b0, 16'd0, 32'h0, 2, "t5 ram0 rd", rd, led, irq_v);
    check("t5 ram0 intact", rd, 32'h12345678);
    check("t5 leds intact", 32'(LEDs), 32'hA);
    access(1'b0, 16'hFF03, 32'h0, 1, "t5 mask rd", rd, led, irq_v);
    check("t5 mask intact", rd, 32'hF);

    // Reset during the wait state of a RAM write
    access(1'b1, 16'd7, 32'h11111111, 2, "t6 pre wr", rd, led, irq_v);
    req = 1'b1; we = 1'b1; address = 16'd7; data_fromCPU = 32'h22222222;
    tick();
    check("t6 wait no ready", 32'(ready), 32'h0);
    reset = 1'b1; req = 1'b0; we = 1'b0; data_fromCPU = '0;
    tick();
    check("t6 rst ready", 32'(ready), 32'h0);
    check("t6 rst data", data_toCPU, 32'h0);
    check("t6 rst leds", 32'(LEDs), 32'h0);
    check("t6 rst irq", 32'(irq), 32'h0);
    reset = 1'b0;
    tick();
    check("t6 no late ready", 32'(ready), 32'h0);
    tick(); tick(); tick();
    access(1'b0, 16'd7, 32'h0, 2, "t6 ram rd", rd, led, irq_v);
    check("t6 ram unchanged", rd, 32'h11111111);
    check("t6 irq masked", 32'(irq_v), 32'h0);
    access(1'b0, 16'hFF02, 32'h0, 1, "t6 chg rd", rd, led, irq_v);
    check("t6 chg after release", rd, 32'h6);
    access(1'b0, 16'hFF03, 32'h0, 1, "t6 mask rd", rd, led, irq_v);
    check("t6 mask reset", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
